// File: rtl/dice_pkg.sv
// Purpose: shared die constants, face-count lookup and roll FSM state encoding.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dice_pkg;

  localparam logic [2:0] DIE_D4   = 3'd0;
  localparam logic [2:0] DIE_D6   = 3'd1;
  localparam logic [2:0] DIE_D8   = 3'd2;
  localparam logic [2:0] DIE_D10  = 3'd3;
  localparam logic [2:0] DIE_D12  = 3'd4;
  localparam logic [2:0] DIE_D20  = 3'd5;
  localparam logic [2:0] DIE_D100 = 3'd6;
  localparam logic [2:0] DIE_LAST = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    TUMBLE  = 2'd2,
    SHOW    = 2'd3
  } state_e;

  // Number of faces on the die selected by idx. Index 7 is never produced;
  // it maps to the smallest die so the spin counter stays bounded anyway.
  function automatic logic [6:0] faces(input logic [2:0] idx);
    logic [6:0] n;
    case (idx)
      DIE_D4:   n = 7'd4;
      DIE_D6:   n = 7'd6;
      DIE_D8:   n = 7'd8;
      DIE_D10:  n = 7'd10;
      DIE_D12:  n = 7'd12;
      DIE_D20:  n = 7'd20;
      DIE_D100: n = 7'd100;
      default:  n = 7'd4;
    endcase
    return n;
  endfunction

  // Cyclic advance through d4 .. d100, wrapping back to d4.
  function automatic logic [2:0] next_die(input logic [2:0] idx);
    return (idx >= DIE_LAST) ? DIE_D4 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/dice_spin_counter.sv
// Purpose: free-running modulo-N counter producing 1..faces, restarted by clear.
// Latency: spin updates one clk after the edge that sees clear/faces.
// Backpressure: none; advances every clk unconditionally.
// Ports: clk, rst_n (async, active-low); clear forces spin to 1;
//        faces is the current modulus; spin is the registered count.
module dice_spin_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [6:0] faces,
  output logic [6:0] spin
);

  logic [6:0] spin_q;
  logic [6:0] spin_d;

  // The >= compare (rather than ==) also pulls an out-of-range count back
  // to 1, e.g. if the modulus shrank without a clear.
  always_comb begin
    spin_d = spin_q + 7'd1;
    if (clear || (spin_q >= faces)) begin
      spin_d = 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spin_q <= 7'd1;
    end else begin
      spin_q <= spin_d;
    end
  end

  assign spin = spin_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Purpose: die select + roll FSM; spins while roll held, tumbles, then shows result.
// Latency: all outputs registered; valid rises on the edge that ends the tumble.
// Backpressure: none; button edges outside the accepting states are dropped.
// Ports: clk, rst_n (async, active-low); tick = slow timebase pulse;
//        roll_btn / sel_btn = debounced levels; die_idx = selected die;
//        value = displayed number (0 = blank); rolling = ROLLING/TUMBLE; valid = SHOW.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TUMBLE_TICKS = 6,
  parameter int DEFAULT_DIE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       roll_btn,
  input  logic       sel_btn,
  output logic [2:0] die_idx,
  output logic [6:0] value,
  output logic       rolling,
  output logic       valid
);

  localparam int TW = (TUMBLE_TICKS > 0) ? $clog2(TUMBLE_TICKS + 1) : 1;

  state_e          state_q, state_d;
  logic [2:0]      die_q, die_d;
  logic [6:0]      value_q, value_d;
  logic [6:0]      captured_q, captured_d;
  logic [TW-1:0]   tumble_q, tumble_d;
  logic            roll_q, sel_q;
  logic [6:0]      spin;

  // History resets high so a button held through reset is not a press.
  logic roll_rise, roll_fall, sel_rise;
  assign roll_rise = roll_btn & ~roll_q;
  assign roll_fall = ~roll_btn & roll_q;
  assign sel_rise  = sel_btn & ~sel_q;

  dice_spin_counter u_spin (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (die_d != die_q),
    .faces (faces(die_q)),
    .spin  (spin)
  );

  always_comb begin
    state_d    = state_q;
    die_d      = die_q;
    value_d    = value_q;
    captured_d = captured_q;
    tumble_d   = tumble_q;
    case (state_q)
      IDLE: begin
        value_d = 7'd0;
        // roll has priority; a coincident sel press is discarded
        if (roll_rise) begin
          state_d = ROLLING;
        end else if (sel_rise) begin
          die_d = next_die(die_q);
        end
      end
      ROLLING: begin
        if (tick) begin
          value_d = spin;
        end
        // Fall wins over a coincident tick; spin here is the pre-edge count.
        if (roll_fall) begin
          captured_d = spin;
          tumble_d   = TW'(TUMBLE_TICKS);
          if (TUMBLE_TICKS == 0) begin
            value_d = spin;
            state_d = SHOW;
          end else begin
            state_d = TUMBLE;
          end
        end
      end
      TUMBLE: begin
        if (tick) begin
          if (tumble_q > TW'(1)) begin
            tumble_d = tumble_q - TW'(1);
            value_d  = spin;
          end else begin
            tumble_d = '0;
            value_d  = captured_q;
            state_d  = SHOW;
          end
        end
      end
      SHOW: begin
        if (roll_rise) begin
          state_d = ROLLING;
        end else if (sel_rise) begin
          die_d   = next_die(die_q);
          value_d = 7'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      die_q      <= 3'(DEFAULT_DIE);
      value_q    <= 7'd0;
      captured_q <= 7'd0;
      tumble_q   <= '0;
      roll_q     <= 1'b1;
      sel_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      die_q      <= die_d;
      value_q    <= value_d;
      captured_q <= captured_d;
      tumble_q   <= tumble_d;
      roll_q     <= roll_btn;
      sel_q      <= sel_btn;
    end
  end

  assign die_idx = die_q;
  assign value   = value_q;
  assign rolling = (state_q == ROLLING) || (state_q == TUMBLE);
  assign valid   = (state_q == SHOW);

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Purpose: directed self-checking bench for dice_roll_ctrl (tumble=6 and tumble=0 instances).
// Latency: checks sampled 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_dice_roll_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       roll6 = 1'b0, sel6 = 1'b0;
  logic       roll0 = 1'b0, sel0 = 1'b0;
  logic [2:0] die6, die0;
  logic [6:0] val6, val0;
  logic       rolling6, valid6, rolling0, valid0;

  int  n_cmp = 0;
  int  n_bad = 0;
  time last_edge = 0;
  time chg6_t = 0;
  time chg0_t = 0;
  int  tcnt = 0;

  dice_roll_ctrl #(.TUMBLE_TICKS(6), .DEFAULT_DIE(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .roll_btn(roll6), .sel_btn(sel6),
    .die_idx(die6), .value(val6), .rolling(rolling6), .valid(valid6)
  );

  dice_roll_ctrl #(.TUMBLE_TICKS(0), .DEFAULT_DIE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .roll_btn(roll0), .sel_btn(sel0),
    .die_idx(die0), .value(val0), .rolling(rolling0), .valid(valid0)
  );

  always #5 clk = ~clk;

  // One-clk tick every 16 clk, changed 2 units after the edge so that it is
  // stable when the main process looks at it 1 unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tcnt == 15) begin
        tcnt = 0;
        tick = 1'b1;
      end else begin
        tcnt = tcnt + 1;
        tick = 1'b0;
      end
    end
  end

  // Returns 1 unit after the next rising edge: outputs of that edge are
  // settled and new inputs driven here are seen by the following edge.
  task automatic next_cyc();
    @(posedge clk);
    last_edge = $time;
    #1;
  endtask

  // Spin value held just before edge f_t, given the die changed at edge c_t
  // (spin is 1 right after a die change and counts 1..n every clk).
  function automatic int exp_spin(time f_t, time c_t, int n);
    int d;
    d = int'((f_t - c_t) / 10) - 1;
    return (d % n) + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sel6  = 1'b1;
    sel0  = 1'b1;
    #12;
    n_cmp++; if (die6 !== 3'd1)     begin n_bad++; $display("FAIL reset_die got=%0d exp=1", die6); end
    n_cmp++; if (val6 !== 7'd0)     begin n_bad++; $display("FAIL reset_value got=%0d exp=0", val6); end
    n_cmp++; if (rolling6 !== 1'b0) begin n_bad++; $display("FAIL reset_rolling got=%b exp=0", rolling6); end
    n_cmp++; if (valid6 !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid6); end
    next_cyc();
    rst_n = 1'b1;
    repeat (3) next_cyc();
    n_cmp++; if (die6 !== 3'd1) begin n_bad++; $display("FAIL sel_held_through_reset got=%0d exp=1", die6); end
    sel6 = 1'b0;
    sel0 = 1'b0;
    next_cyc();
    n_cmp++; if (die6 !== 3'd1) begin n_bad++; $display("FAIL sel_release got=%0d exp=1", die6); end
    n_cmp++; if (val6 !== 7'd0) begin n_bad++; $display("FAIL idle_value got=%0d exp=0", val6); end
  endtask

  task automatic test_die_cycle();
    logic [2:0] exp_seq [7];
    exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    for (int i = 0; i < 7; i++) begin
      next_cyc();
      sel6 = 1'b1;
      if (i < 5) sel0 = 1'b1;
      next_cyc();
      chg6_t = last_edge;
      if (i == 4) chg0_t = last_edge;
      n_cmp++;
      if (die6 !== exp_seq[i]) begin
        n_bad++; $display("FAIL die_step%0d got=%0d exp=%0d", i, die6, exp_seq[i]);
      end
      if (i < 5) begin
        n_cmp++;
        if (die0 !== exp_seq[i]) begin
          n_bad++; $display("FAIL die0_step%0d got=%0d exp=%0d", i, die0, exp_seq[i]);
        end
      end
      sel6 = 1'b0;
      sel0 = 1'b0;
      next_cyc();
    end
  endtask

  task automatic test_roll_tumble();
    int  exp_v;
    int  ticks;
    bit  done;
    next_cyc();
    roll6 = 1'b1;
    next_cyc();
    n_cmp++; if (rolling6 !== 1'b1) begin n_bad++; $display("FAIL roll_start got=%b exp=1", rolling6); end
    repeat (36) next_cyc();
    roll6 = 1'b0;
    next_cyc();
    exp_v = exp_spin(last_edge, chg6_t, 6);
    n_cmp++; if (rolling6 !== 1'b1) begin n_bad++; $display("FAIL tumble_entry_rolling got=%b exp=1", rolling6); end
    ticks = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      next_cyc();
      if (tick) ticks++;
      if (ticks < 6) begin
        n_cmp++;
        if (rolling6 !== 1'b1 || valid6 !== 1'b0) begin
          n_bad++; $display("FAIL tumble_hold ticks=%0d rolling=%b valid=%b exp rolling=1 valid=0", ticks, rolling6, valid6);
        end
      end else begin
        done = 1'b1;
        n_cmp++; if (valid6 !== 1'b1) begin n_bad++; $display("FAIL tumble_valid got=%b exp=1", valid6); end
        n_cmp++; if (val6 !== 7'(exp_v)) begin n_bad++; $display("FAIL tumble_result got=%0d exp=%0d", val6, exp_v); end
        n_cmp++; if (rolling6 !== 1'b0) begin n_bad++; $display("FAIL show_rolling got=%b exp=0", rolling6); end
      end
    end
    if (!done) begin
      n_cmp++; n_bad++; $display("FAIL tumble_timeout ticks=%0d exp=6", ticks);
    end
  endtask

  task automatic test_d100_sweep();
    int seen [1:100];
    int exp_v;
    for (int v = 1; v <= 100; v++) seen[v] = 0;
    // 101 clk per iteration, so each release lands one spin step later mod 100.
    for (int k = 0; k < 100; k++) begin
      next_cyc();
      roll0 = 1'b1;
      next_cyc();
      repeat (40) next_cyc();
      n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL d100_prefall_valid k=%0d got=%b exp=0", k, valid0); end
      roll0 = 1'b0;
      next_cyc();
      exp_v = exp_spin(last_edge, chg0_t, 100);
      n_cmp++;
      if (valid0 !== 1'b1 || val0 !== 7'(exp_v)) begin
        n_bad++; $display("FAIL d100_result k=%0d valid=%b value=%0d exp valid=1 value=%0d", k, valid0, val0, exp_v);
      end
      if (val0 >= 7'd1 && val0 <= 7'd100) seen[int'(val0)]++;
      repeat (58) next_cyc();
    end
    for (int v = 1; v <= 100; v++) begin
      n_cmp++;
      if (seen[v] !== 1) begin n_bad++; $display("FAIL d100_coverage value=%0d seen=%0d exp=1", v, seen[v]); end
    end
  endtask

  task automatic test_show_collision();
    next_cyc();
    roll6 = 1'b1;
    sel6  = 1'b1;
    next_cyc();
    n_cmp++; if (rolling6 !== 1'b1) begin n_bad++; $display("FAIL collide_rolling got=%b exp=1", rolling6); end
    n_cmp++; if (valid6 !== 1'b0)   begin n_bad++; $display("FAIL collide_valid got=%b exp=0", valid6); end
    n_cmp++; if (die6 !== 3'd1)     begin n_bad++; $display("FAIL collide_die got=%0d exp=1", die6); end
    sel6 = 1'b0;
    next_cyc();
    roll6 = 1'b0;
    next_cyc();
    next_cyc();
    sel6 = 1'b1;
    next_cyc();
    n_cmp++; if (die6 !== 3'd1)     begin n_bad++; $display("FAIL tumble_sel_die got=%0d exp=1", die6); end
    n_cmp++; if (rolling6 !== 1'b1) begin n_bad++; $display("FAIL tumble_sel_rolling got=%b exp=1", rolling6); end
    sel6 = 1'b0;
  endtask

  task automatic test_reset_mid_tumble();
    next_cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (val6 !== 7'd0)     begin n_bad++; $display("FAIL rst_value got=%0d exp=0", val6); end
    n_cmp++; if (rolling6 !== 1'b0) begin n_bad++; $display("FAIL rst_rolling got=%b exp=0", rolling6); end
    n_cmp++; if (valid0 !== 1'b0)   begin n_bad++; $display("FAIL rst_valid0 got=%b exp=0", valid0); end
    n_cmp++; if (die0 !== 3'd1)     begin n_bad++; $display("FAIL rst_die0 got=%0d exp=1", die0); end
    next_cyc();
    rst_n = 1'b1;
    repeat (3) next_cyc();
    n_cmp++; if (val6 !== 7'd0)     begin n_bad++; $display("FAIL post_rst_value got=%0d exp=0", val6); end
    n_cmp++; if (rolling6 !== 1'b0) begin n_bad++; $display("FAIL post_rst_rolling got=%b exp=0", rolling6); end
    n_cmp++; if (valid6 !== 1'b0)   begin n_bad++; $display("FAIL post_rst_valid got=%b exp=0", valid6); end
  endtask

  initial begin
    test_reset();
    test_die_cycle();
    test_roll_tumble();
    test_d100_sweep();
    test_show_collision();
    test_reset_mid_tumble();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
- Roll controller directly downstream of the button debouncers.
- Consumes the debounced "roll" and "select" button levels plus the shared slow timebase tick.
- Cycles the selected die type (d4, d6, d8, d10, d12, d20, d100).
- While roll is held, spins a per-clock modulo-N counter; on release, captures it as the result, plays a short tumble animation, then presents the final value to the display stage.

Parameters:
- TUMBLE_TICKS, 6: number of tick periods of tumble animation after release; 0 means show the result immediately.
- DEFAULT_DIE, 1: die index loaded at reset (1 = d6).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- tick  input  1  one-clk-wide timebase pulse, same tick that drives the debouncers.
- roll_btn  input  1  debounced roll button level.
- sel_btn  input  1  debounced die-select button level.
- die_idx  output  3  selected die: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d100; 7 is never produced.
- value  output  7  displayed number, 1..100; 0 when nothing is to be shown.
- rolling  output  1  high in ROLLING and TUMBLE.
- valid  output  1  high only in SHOW; value is then the final result.

Behaviour:
- Reset (async assert, all registers):
  - state=IDLE, die_idx=DEFAULT_DIE, value=0, rolling=0, valid=0, spin=1, captured=0, tumble_cnt=0.
  - Both edge-detect history registers reset to 1, so a button held through reset must be released before it counts as a press.
- Edge detect: rise = btn & ~btn_q; fall = ~btn & btn_q. btn_q is updated every clk.
- Spin counter: 7 bits, advances every clk with no tick gating.
  - spin <= (spin >= faces(die_idx)) ? 1 : spin+1.
  - Forced to 1 in the cycle die_idx changes.
  - Always in 1..faces; the >= compare also recovers any out-of-range value.
- States and transitions:
  - IDLE: value=0.
    - roll rise -> ROLLING.
    - Else sel rise -> die_idx <= (die_idx==6) ? 0 : die_idx+1; stay IDLE.
  - ROLLING: on each tick, value <= spin.
    - roll fall -> captured <= spin (value in that same cycle), tumble_cnt <= TUMBLE_TICKS.
    - Next state is TUMBLE, or SHOW with value <= spin when TUMBLE_TICKS==0.
    - sel ignored.
  - TUMBLE: on each tick, tumble_cnt--; value <= spin while tumble_cnt>1.
    - On the tick with tumble_cnt==1: value <= captured, go SHOW.
    - roll and sel ignored.
  - SHOW: value holds the result, valid=1.
    - roll rise -> ROLLING, valid drops next cycle.
    - Else sel rise -> advance die_idx, value <= 0, go IDLE.
- Outputs are registered. rolling and valid are decoded from the state register, so valid is high in the first SHOW cycle.
- Simultaneous roll rise and sel rise in IDLE or SHOW: roll wins, sel is dropped (not queued).
- Simultaneous tick and roll fall in ROLLING: the fall is taken; captured uses the pre-update spin.
- A roll press shorter than one tick still produces a valid roll; value may stay 0 until the TUMBLE ticks.
- Result is never 0 and never greater than faces(die_idx) for the die active at capture.
- Async reset mid-roll or mid-tumble aborts to reset state; no result is retained.
- tumble_cnt width: $clog2(TUMBLE_TICKS+1), minimum 1.

Decomposition:
- Shared package dice_pkg holds:
  - die index constants (DIE_D4..DIE_D100, DIE_LAST=6);
  - a faces(idx) lookup function returning 4, 6, 8, 10, 12, 20, 100;
  - the state enum (IDLE, ROLLING, TUMBLE, SHOW).
- One natural sub-module, dice_spin_counter: modulo-N 1..N counter with clear input and faces input.
- Edge detection and the FSM stay in dice_roll_ctrl.

Test Plan:
- Reset, no presses -> die_idx=1, value=0, valid=0, rolling=0; sel_btn held high through reset -> no die change until released and re-pressed.
- Six sel presses from reset -> die_idx steps 2,3,4,5,6,0. A seventh press -> 1.
- d6, tick every 16 clk, TUMBLE_TICKS=6: hold roll 37 clk, release.
  - Expect rolling=1 through the tumble.
  - After exactly 6 ticks: valid=1 and value equals the model's spin at the release cycle, in 1..6.
- die d100, TUMBLE_TICKS=0, sweep the release cycle over 100 consecutive offsets -> every value 1..100 appears exactly once, with valid the cycle after the fall.
- In SHOW, roll and sel rise in the same cycle -> ROLLING entered, die_idx unchanged, valid=0 the next cycle. sel pressed during TUMBLE -> die_idx unchanged.
- Assert rst_n low mid-TUMBLE (between clk edges) -> outputs go to reset values immediately; after release, IDLE with value=0.
